// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM controller for a multicycle MIPS datapath with a unified memory.
// Sequences each instruction, drives datapath enables/selects and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_J    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic        pcen,
  output logic [2:0]  alucontrol,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      state_r;
  state_t      state_next;
  state_t      cur;
  logic [31:0] instret_r;
  logic        retire;
  logic        illegal_dec;
  logic        pcwrite;
  logic        branch;
  logic        memwrite_dec;
  logic        irwrite_dec;
  logic        regwrite_dec;
  logic [1:0]  aluop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= FETCH;
      instret_r <= 32'd0;
    end else begin
      state_r <= state_next;
      if (retire) begin
        instret_r <= instret_r + 32'd1;
      end
    end
  end

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_next  = FETCH;
    illegal_dec = 1'b0;
    retire      = 1'b0;
    case (state_r)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI: begin
            if (ENABLE_ADDI) state_next = ADDIEXEC;
            else             illegal_dec = 1'b1;
          end
          OP_J: begin
            if (ENABLE_J) state_next = JUMP;
            else          illegal_dec = 1'b1;
          end
          default:      illegal_dec = 1'b1;
        endcase
      end
      MEMADR:   state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_next = MEMWB;
      EXECUTE:  state_next = ALUWB;
      ADDIEXEC: state_next = ADDIWB;
      MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      default:  state_next = FETCH;
    endcase
  end

  // While reset is held the outputs present the FETCH decode.
  always_comb begin
    cur = reset ? FETCH : state_r;
  end

  // Moore output decode of the current state.
  always_comb begin
    iord         = 1'b0;
    memwrite_dec = 1'b0;
    irwrite_dec  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_dec = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = 2'b00;
    case (cur)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_dec = 1'b1;
        pcwrite     = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_dec = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_dec = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_dec = 1'b1;
      end
      ADDIWB:  regwrite_dec = 1'b1;
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: aluop = 2'b00;
    endcase
  end

  // ALU decoder.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign memwrite = memwrite_dec & ~reset;
  assign irwrite  = irwrite_dec & ~reset;
  assign regwrite = regwrite_dec & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign illegal  = illegal_dec & ~reset;
  assign state    = cur;
  assign instret  = instret_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table, corner-case
// sequences and randomized instruction streams against an instruction-level model.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] R_OP = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;

  logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        iord2, memwrite2, irwrite2, regdst2, memtoreg2, regwrite2, alusrca2, pcen2, illegal2;
  logic [1:0]  alusrcb2, pcsrc2;
  logic [2:0]  alucontrol2;
  logic [3:0]  state2;
  logic [31:0] instret2;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal),
    .state(state), .instret(instret)
  );

  mips_multicycle_ctrl #(.ENABLE_ADDI(1'b1), .ENABLE_J(1'b0)) dut_noj (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord2), .memwrite(memwrite2), .irwrite(irwrite2), .regdst(regdst2),
    .memtoreg(memtoreg2), .regwrite(regwrite2), .alusrca(alusrca2), .alusrcb(alusrcb2),
    .pcsrc(pcsrc2), .pcen(pcen2), .alucontrol(alucontrol2), .illegal(illegal2),
    .state(state2), .instret(instret2)
  );

  logic [15:0] bund;
  assign bund = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then let outputs settle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z);
    @(posedge clk);
    #1;
    reset = r; op = o; funct = f; zero = z;
    #3;
  endtask

  function automatic bit is_legal(input logic [5:0] o, input bit en_j);
    return (o == LW) || (o == SW) || (o == R_OP) || (o == BEQ) || (o == ADDI) ||
           (en_j && (o == JMP));
  endfunction

  typedef int seq_t[$];

  // State trail of one instruction, from its fetch to its last cycle.
  function automatic seq_t trail(input logic [5:0] o);
    seq_t q;
    if (o == LW)             q = '{0, 1, 2, 3, 4};
    else if (o == SW)        q = '{0, 1, 2, 5};
    else if (o == R_OP)      q = '{0, 1, 6, 7};
    else if (o == BEQ)       q = '{0, 1, 8};
    else if (o == ADDI)      q = '{0, 1, 9, 10};
    else if (o == JMP)       q = '{0, 1, 11};
    else                     q = '{0, 1};
    return q;
  endfunction

  function automatic logic [15:0] exp_bundle(input int s_in, input logic r, input logic [5:0] o,
                                             input logic [5:0] f, input logic z, input bit en_j);
    logic io, mw, irw, rd, m2r, rw, asa, pw, br, ill, pe;
    logic [1:0] asb, ps, aop;
    logic [2:0] ac;
    int s;
    s = r ? 0 : s_in;
    {io, mw, irw, rd, m2r, rw, asa, pw, br, ill} = 10'b0;
    asb = 2'b00; ps = 2'b00; aop = 2'b00;
    case (s)
      0: begin asb = 2'b01; irw = 1'b1; pw = 1'b1; end
      1: asb = 2'b11;
      2, 9: begin asa = 1'b1; asb = 2'b10; end
      3: io = 1'b1;
      4: begin m2r = 1'b1; rw = 1'b1; end
      5: begin io = 1'b1; mw = 1'b1; end
      6: begin asa = 1'b1; aop = 2'b10; end
      7: begin rd = 1'b1; rw = 1'b1; end
      8: begin asa = 1'b1; aop = 2'b01; ps = 2'b01; br = 1'b1; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pw = 1'b1; end
      default: aop = 2'b00;
    endcase
    ill = (s == 1) && !is_legal(o, en_j);
    if (aop == 2'b01) ac = 3'b110;
    else if (aop == 2'b10) begin
      if (f == 6'b100010)      ac = 3'b110;
      else if (f == 6'b100100) ac = 3'b000;
      else if (f == 6'b100101) ac = 3'b001;
      else if (f == 6'b101010) ac = 3'b111;
      else                     ac = 3'b010;
    end else ac = 3'b010;
    pe = pw || (br && z);
    if (r) begin mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0; pe = 1'b0; end
    return {io, mw, irw, rd, m2r, rw, asa, asb, ps, pe, ac, ill};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic        pcen;
    logic [2:0]  aluc;
    logic        ill;
    logic [31:0] ir;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                              input logic [3:0] s, input logic p, input logic [2:0] a,
                              input logic i, input logic [31:0] n);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.st = s;
    v.pcen = p; v.aluc = a; v.ill = i; v.ir = n;
    return v;
  endfunction

  vec_t tbl[25];
  int   cnt;
  seq_t q;

  initial begin
    tbl[0]  = mk(1'b1, R_OP, 6'd0, 1'b0, 4'd0, 1'b0, 3'b010, 1'b0, 32'd0);
    tbl[1]  = mk(1'b0, LW,   6'd0, 1'b0, 4'd0, 1'b1, 3'b010, 1'b0, 32'd0);
    tbl[2]  = mk(1'b0, LW,   6'd0, 1'b0, 4'd1, 1'b0, 3'b010, 1'b0, 32'd0);
    tbl[3]  = mk(1'b0, LW,   6'd0, 1'b0, 4'd2, 1'b0, 3'b010, 1'b0, 32'd0);
    tbl[4]  = mk(1'b0, LW,   6'd0, 1'b0, 4'd3, 1'b0, 3'b010, 1'b0, 32'd0);
    tbl[5]  = mk(1'b0, LW,   6'd0, 1'b0, 4'd4, 1'b0, 3'b010, 1'b0, 32'd0);
    tbl[6]  = mk(1'b0, R_OP, 6'b101010, 1'b0, 4'd0, 1'b1, 3'b010, 1'b0, 32'd1);
    tbl[7]  = mk(1'b0, R_OP, 6'b101010, 1'b0, 4'd1, 1'b0, 3'b010, 1'b0, 32'd1);
    tbl[8]  = mk(1'b0, R_OP, 6'b101010, 1'b0, 4'd6, 1'b0, 3'b111, 1'b0, 32'd1);
    tbl[9]  = mk(1'b0, R_OP, 6'b101010, 1'b0, 4'd7, 1'b0, 3'b010, 1'b0, 32'd1);
    tbl[10] = mk(1'b0, BEQ,  6'd0, 1'b1, 4'd0, 1'b1, 3'b010, 1'b0, 32'd2);
    tbl[11] = mk(1'b0, BEQ,  6'd0, 1'b1, 4'd1, 1'b0, 3'b010, 1'b0, 32'd2);
    tbl[12] = mk(1'b0, BEQ,  6'd0, 1'b1, 4'd8, 1'b1, 3'b110, 1'b0, 32'd2);
    tbl[13] = mk(1'b0, BEQ,  6'd0, 1'b0, 4'd0, 1'b1, 3'b010, 1'b0, 32'd3);
    tbl[14] = mk(1'b0, BEQ,  6'd0, 1'b0, 4'd1, 1'b0, 3'b010, 1'b0, 32'd3);
    tbl[15] = mk(1'b0, BEQ,  6'd0, 1'b0, 4'd8, 1'b0, 3'b110, 1'b0, 32'd3);
    tbl[16] = mk(1'b0, BAD,  6'd0, 1'b0, 4'd0, 1'b1, 3'b010, 1'b0, 32'd4);
    tbl[17] = mk(1'b0, BAD,  6'd0, 1'b0, 4'd1, 1'b0, 3'b010, 1'b1, 32'd4);
    tbl[18] = mk(1'b0, JMP,  6'd0, 1'b0, 4'd0, 1'b1, 3'b010, 1'b0, 32'd4);
    tbl[19] = mk(1'b0, JMP,  6'd0, 1'b0, 4'd1, 1'b0, 3'b010, 1'b0, 32'd4);
    tbl[20] = mk(1'b0, JMP,  6'd0, 1'b0, 4'd11, 1'b1, 3'b010, 1'b0, 32'd4);
    tbl[21] = mk(1'b0, ADDI, 6'd0, 1'b0, 4'd0, 1'b1, 3'b010, 1'b0, 32'd5);
    tbl[22] = mk(1'b0, ADDI, 6'd0, 1'b0, 4'd1, 1'b0, 3'b010, 1'b0, 32'd5);
    tbl[23] = mk(1'b0, ADDI, 6'd0, 1'b0, 4'd9, 1'b0, 3'b010, 1'b0, 32'd5);
    tbl[24] = mk(1'b0, ADDI, 6'd0, 1'b0, 4'd10, 1'b0, 3'b010, 1'b0, 32'd5);

    cyc(1'b1, R_OP, 6'd0, 1'b0);
    cyc(1'b1, R_OP, 6'd0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].zero);
      chk($sformatf("tbl%0d_state", i), {28'd0, state}, {28'd0, tbl[i].st});
      chk($sformatf("tbl%0d_pcen", i), {31'd0, pcen}, {31'd0, tbl[i].pcen});
      chk($sformatf("tbl%0d_aluc", i), {29'd0, alucontrol}, {29'd0, tbl[i].aluc});
      chk($sformatf("tbl%0d_illegal", i), {31'd0, illegal}, {31'd0, tbl[i].ill});
      chk($sformatf("tbl%0d_instret", i), instret, tbl[i].ir);
    end

    // lw interrupted in MEMRD by a three-cycle reset.
    q = trail(LW);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, LW, 6'd0, 1'b1);
      chk("abort_state", {28'd0, state}, q[k]);
    end
    chk("abort_iord", {31'd0, iord}, 32'd1);
    chk("abort_instret_before", instret, 32'd6);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, LW, 6'd0, 1'b1);
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_writes", {28'd0, pcen, memwrite, regwrite, irwrite}, 32'd0);
      if (k > 0) chk("rst_instret", instret, 32'd0);
    end
    cyc(1'b0, SW, 6'd0, 1'b0);
    chk("post_rst_state", {28'd0, state}, 32'd0);
    chk("post_rst_irwrite_pcen", {30'd0, irwrite, pcen}, 32'd3);
    chk("post_rst_instret", instret, 32'd0);

    // sw: memwrite only in MEMWR, regwrite never set.
    q = trail(SW);
    for (int k = 1; k < q.size(); k++) begin
      cyc(1'b0, SW, 6'd0, 1'b0);
      chk("sw_state", {28'd0, state}, q[k]);
      chk("sw_memwrite", {31'd0, memwrite}, (q[k] == 5) ? 32'd1 : 32'd0);
      chk("sw_regwrite", {31'd0, regwrite}, 32'd0);
    end
    cyc(1'b0, R_OP, 6'b100010, 1'b0);
    chk("sw_instret", instret, 32'd1);

    // Further R-type funct decodes.
    for (int j = 0; j < 2; j++) begin
      logic [5:0] fn;
      logic [2:0] ea;
      fn = (j == 0) ? 6'b100010 : 6'b100101;
      ea = (j == 0) ? 3'b110 : 3'b001;
      if (j == 1) cyc(1'b0, R_OP, fn, 1'b0);
      cyc(1'b0, R_OP, fn, 1'b0);
      cyc(1'b0, R_OP, fn, 1'b0);
      chk("rtype_exec_state", {28'd0, state}, 32'd6);
      chk("rtype_aluc", {29'd0, alucontrol}, {29'd0, ea});
      cyc(1'b0, R_OP, fn, 1'b0);
      chk("rtype_regdst", {30'd0, regdst, regwrite}, 32'd3);
    end

    // j with ENABLE_J=0 behaves as an illegal opcode.
    cyc(1'b1, JMP, 6'd0, 1'b0);
    cyc(1'b0, JMP, 6'd0, 1'b0);
    chk("noj_fetch", {28'd0, state2}, 32'd0);
    cyc(1'b0, JMP, 6'd0, 1'b0);
    chk("noj_illegal", {31'd0, illegal2}, 32'd1);
    chk("j_not_illegal", {31'd0, illegal}, 32'd0);
    cyc(1'b0, JMP, 6'd0, 1'b0);
    chk("noj_back_to_fetch", {28'd0, state2}, 32'd0);
    chk("noj_illegal_pulse", {31'd0, illegal2}, 32'd0);
    chk("j_state", {28'd0, state}, 32'd11);
    cyc(1'b0, JMP, 6'd0, 1'b0);
    chk("noj_instret", instret2, 32'd0);
    chk("j_instret", instret, 32'd1);

    // Random instruction stream with occasional resets.
    cyc(1'b1, R_OP, 6'd0, 1'b0);
    cnt = 0;
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      int kind;
      kind = $urandom_range(0, 6);
      case (kind)
        0: o = LW;
        1: o = SW;
        2: o = R_OP;
        3: o = BEQ;
        4: o = ADDI;
        5: o = JMP;
        default: begin
          int b;
          b = $urandom_range(0, 3);
          o = (b == 0) ? 6'b111111 : (b == 1) ? 6'b000001 : (b == 2) ? 6'b001100 : 6'b100000;
        end
      endcase
      case ($urandom_range(0, 6))
        0: f = 6'b100000;
        1: f = 6'b100010;
        2: f = 6'b100100;
        3: f = 6'b100101;
        4: f = 6'b101010;
        default: f = 6'($urandom);
      endcase
      q = trail(o);
      for (int k = 0; k < q.size(); k++) begin
        logic z, r;
        z = 1'($urandom_range(0, 1));
        r = ($urandom_range(0, 39) == 0);
        cyc(r, o, f, z);
        chk("rnd_bundle", {16'd0, bund}, {16'd0, exp_bundle(q[k], r, o, f, z, 1'b1)});
        chk("rnd_state", {28'd0, state}, r ? 32'd0 : q[k]);
        chk("rnd_instret", instret, cnt);
        if (r) begin
          cnt = 0;
          break;
        end
        if (k == q.size() - 1 && is_legal(o, 1'b1)) cnt++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
